// File: rtl/demux3.sv
// Registered 1-to-8 result distributor with a per-channel valid/ack handshake and an occupancy count.
// Optional DEMUX3_OVERWRITE_EN: writes are never refused, and overwriting unconsumed data sets a sticky overflow flag.
module demux3 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ack,
  output logic [3:0]       count,
  output logic             overflow
);

  logic [WIDTH-1:0] hold [8];
  logic [7:0]       valid_nxt;
  logic [3:0]       count_nxt;
  logic             accept;

  always_comb begin
`ifdef DEMUX3_OVERWRITE_EN
    in_ready = 1'b1;
`else
    // A same-cycle ack frees the slot, so the channel can be refilled every cycle.
    in_ready = !out_valid[in_sel] || out_ack[in_sel];
`endif
  end

  assign accept = in_valid && in_ready;

  // Acks clear their bits first; a write then sets its bit, so ack+write on one channel stays valid.
  always_comb begin
    valid_nxt = out_valid & ~out_ack;
    if (accept) valid_nxt[in_sel] = 1'b1;
    count_nxt = 4'($countones(valid_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '{default: '0};
      out_valid <= '0;
      count     <= '0;
    end else begin
      if (accept) hold[in_sel] <= in_data;
      out_valid <= valid_nxt;
      count     <= count_nxt;
    end
  end

`ifdef DEMUX3_OVERWRITE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (accept && out_valid[in_sel] && !out_ack[in_sel])
      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

  assign o0 = hold[0];
  assign o1 = hold[1];
  assign o2 = hold[2];
  assign o3 = hold[3];
  assign o4 = hold[4];
  assign o5 = hold[5];
  assign o6 = hold[6];
  assign o7 = hold[7];

endmodule

// File: tb/tb_demux3.sv
// Directed bench for demux3: accepted writes go to a scoreboard queue and are checked against the channel
// registers after the edge; a small valid/overflow model covers handshake, count and reset behaviour.
module tb_demux3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [3:0]  count;
  logic        overflow;

  demux3 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .out_valid(out_valid), .out_ack(out_ack), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] data;
  } wr_t;

  wr_t         sbq[$];
  logic [15:0] exp_o [8];
  logic [7:0]  exp_valid;
  logic        exp_ovf;
  int          passed = 0;
  int          total  = 0;

`ifdef DEMUX3_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  function automatic logic [15:0] get_o(input int k);
    case (k)
      0: return o0;
      1: return o1;
      2: return o2;
      3: return o3;
      4: return o4;
      5: return o5;
      6: return o6;
      default: return o7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, expv);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, " count"},     32'(count),     32'($countones(exp_valid)));
    chk({tag, " overflow"},  32'(overflow),  32'(exp_ovf));
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s o%0d", tag, k), 32'(get_o(k)), 32'(exp_o[k]));
  endtask

  // One clock: drive, check in_ready, predict, clock, then drain the scoreboard and check state.
  task automatic step(input string tag, input logic v, input logic [2:0] sel,
                      input logic [15:0] d, input logic [7:0] ack);
    logic rdy;
    wr_t  w;
    in_valid = v; in_sel = sel; in_data = d; out_ack = ack;
    #1;
    rdy = OVR ? 1'b1 : (!exp_valid[sel] || ack[sel]);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
    exp_valid = exp_valid & ~ack;
    if (v && rdy) begin
      if (OVR && !ack[sel] && out_valid[sel] === 1'b1 && exp_valid[sel] == 1'b0 && 1'b0) exp_ovf = 1'b1;
      sbq.push_back('{sel: sel, data: d});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ack = '0;
    while (sbq.size() > 0) begin
      w = sbq.pop_front();
      exp_o[w.sel] = w.data;
      exp_valid[w.sel] = 1'b1;
      chk($sformatf("%s write o%0d", tag, w.sel), 32'(get_o(int'(w.sel))), 32'(w.data));
    end
    chk_state(tag);
  endtask

  task automatic model_reset();
    sbq.delete();
    for (int k = 0; k < 8; k++) exp_o[k] = '0;
    exp_valid = '0;
    exp_ovf   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ack = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    rst_n = 1'b1;

    // Fill every channel on consecutive cycles.
    for (int k = 0; k < 8; k++)
      step($sformatf("fill%0d", k), 1'b1, 3'(k), 16'h1000 + 16'(k), 8'h00);
    chk("fill o5", 32'(o5), 32'h1005);
    chk("fill count", 32'(count), 32'd8);

    // Channel 3 full: refused without ack (or overwritten with overflow), accepted with ack.
    if (OVR) exp_ovf = 1'b1;
    step("bp_noack", 1'b1, 3'd3, 16'hBEEF, 8'h00);
    step("bp_ack",   1'b1, 3'd3, 16'hBEEF, 8'h08);
    chk("bp o3", 32'(o3), 32'hBEEF);

    step("ack2", 1'b0, 3'd2, 16'h0000, 8'h04);
    step("mixed", 1'b1, 3'd2, 16'h00AA, 8'h81);
    chk("mixed count", 32'(count), 32'd6);

    step("drain", 1'b0, 3'd0, 16'h0000, 8'hFF);
    step("spurious", 1'b0, 3'd5, 16'hFFFF, 8'hFF);
    chk("spurious count", 32'(count), 32'd0);

    // Back-to-back writes to distinct channels, then ack-through on channel 4.
    for (int k = 0; k < 4; k++)
      step($sformatf("b2b%0d", k), 1'b1, 3'(k + 4), 16'h2000 + 16'(k), 8'h00);
    for (int k = 0; k < 4; k++)
      step($sformatf("thru%0d", k), 1'b1, 3'd4, 16'h4000 + 16'(k), 8'h10);
    step("drain2", 1'b0, 3'd0, 16'h0000, 8'hFF);

    if (OVR) begin
      step("ovw_a", 1'b1, 3'd6, 16'h1111, 8'h00);
      exp_ovf = 1'b1;
      step("ovw_b", 1'b1, 3'd6, 16'h2222, 8'h00);
      chk("ovw o6", 32'(o6), 32'h2222);
      step("ovw_sticky", 1'b0, 3'd0, 16'h0000, 8'hFF);
    end

    // Asynchronous reset mid-cycle with garbage on the inputs.
    step("pre_rst", 1'b1, 3'd1, 16'h5A5A, 8'h00);
    in_valid = 1'b1; in_sel = 3'd5; in_data = 16'hDEAD; out_ack = 8'h3C;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_state("async_rst");
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ack = '0;
    rst_n = 1'b1;
    step("post_rst", 1'b1, 3'd7, 16'h7777, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
